module_controle: RTL and testbench

Control unit for the Mini-CPU. It takes one 18-bit instruction from the switches each time `enviar` is pressed and sequences the register RAM and the ALU for that instruction. For each instruction it reads the operands from the 16×16 register RAM, holds them stable on the ALU inputs, writes the ALU result back, sweeps the RAM for CLEAR, and latches a register for DISPLAY. It sits between the switch/button inputs, the ALU and the RAM, and is the only writer of the RAM.

---
 rtl/module_controle_if.sv | 26 ++
 rtl/module_controle.sv | 175 +++++++++++++++++
 tb/tb_module_controle.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/module_controle_if.sv
// RAM and ALU bus of the Mini-CPU control unit.
// The controller owns the master side; RAM and ALU sit on the slave side.
interface module_controle_if;
    logic [3:0]  ramEndereco;
    logic        ramEscrever;
    logic [15:0] ramDadoEscrever;
    logic [15:0] ramDadoLido;
    logic [15:0] valorGuardarULA;
    logic [2:0]  opcodeULA;
    logic        sinalImmULA;
    logic [5:0]  ImmULA;
    logic [15:0] v1ULA;
    logic [15:0] v2ULA;

    modport master (
        output ramEndereco, ramEscrever, ramDadoEscrever,
        output opcodeULA, sinalImmULA, ImmULA, v1ULA, v2ULA,
        input  ramDadoLido, valorGuardarULA
    );

    modport slave (
        input  ramEndereco, ramEscrever, ramDadoEscrever,
        input  opcodeULA, sinalImmULA, ImmULA, v1ULA, v2ULA,
        output ramDadoLido, valorGuardarULA
    );
endinterface

// File: rtl/module_controle.sv
// Mini-CPU control unit: decodes one 18-bit instruction per button press and
// sequences RAM reads, ALU operand hold, write-back, CLEAR sweep and DISPLAY.
module module_controle (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enviar,
    input  logic [17:0]             instrucao,
    module_controle_if.master       bus,
    output logic [15:0]             valorDisplay,
    output logic [3:0]              regDisplay,
    output logic                    ocupado,
    output logic                    pronto
);

    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    typedef enum logic [2:0] {
        OCIOSO, LER_A, LER_B, EXECUTAR, ESCREVER, LIMPAR, MOSTRAR, FIM
    } state_t;

    state_t      state_q, state_d;
    logic        enviar_q;
    logic [2:0]  opcode_q, opcode_d;
    logic [3:0]  dest_q, dest_d;
    logic [3:0]  src1_q, src1_d;
    logic [3:0]  src2_q, src2_d;
    logic        sinal_q, sinal_d;
    logic [5:0]  imm_q, imm_d;
    logic [3:0]  addr_q, addr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] v1_q, v1_d;
    logic [15:0] v2_q, v2_d;
    logic [15:0] disp_q, disp_d;
    logic [3:0]  regdisp_q, regdisp_d;
    logic        start;
    logic        we;
    logic [15:0] wdata;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        start     = enviar && !enviar_q;
        state_d   = state_q;
        opcode_d  = opcode_q;
        dest_d    = dest_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        sinal_d   = sinal_q;
        imm_d     = imm_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        v1_d      = v1_q;
        v2_d      = v2_q;
        disp_d    = disp_q;
        regdisp_d = regdisp_q;
        we        = 1'b0;
        wdata     = 16'h0000;

        case (state_q)
            OCIOSO: begin
                if (start) begin
                    opcode_d = instrucao[17:15];
                    dest_d   = instrucao[14:11];
                    src1_d   = instrucao[10:7];
                    src2_d   = instrucao[6:3];
                    sinal_d  = instrucao[6];
                    imm_d    = instrucao[5:0];
                    case (instrucao[17:15])
                        OP_LOAD:  state_d = EXECUTAR;
                        OP_CLEAR: state_d = LIMPAR;
                        default:  state_d = LER_A;
                    endcase
                end
            end
            LER_A: begin
                if (opcode_q == OP_DISPLAY) begin
                    addr_d  = dest_q;
                    state_d = MOSTRAR;
                end else begin
                    addr_d  = src1_q;
                    state_d = LER_B;
                end
            end
            LER_B: begin
                v1_d    = bus.ramDadoLido;
                addr_d  = src2_q;
                state_d = EXECUTAR;
            end
            EXECUTAR: begin
                v2_d    = (opcode_q == OP_ADD || opcode_q == OP_SUB) ? bus.ramDadoLido : 16'h0000;
                state_d = ESCREVER;
            end
            ESCREVER: begin
                we      = 1'b1;
                addr_d  = dest_q;
                wdata   = bus.valorGuardarULA;
                state_d = FIM;
            end
            LIMPAR: begin
                we     = 1'b1;
                addr_d = cnt_q;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    cnt_d   = 4'd0;
                    state_d = FIM;
                end
            end
            MOSTRAR: begin
                disp_d    = bus.ramDadoLido;
                regdisp_d = dest_q;
                state_d   = FIM;
            end
            FIM:     state_d = OCIOSO;
            default: state_d = OCIOSO;
        endcase

        // A reset cycle must not commit the in-flight write, so a partial CLEAR stops cleanly.
        if (reset) begin
            we    = 1'b0;
            wdata = 16'h0000;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= OCIOSO;
            enviar_q  <= 1'b1;
            opcode_q  <= 3'd0;
            dest_q    <= 4'd0;
            src1_q    <= 4'd0;
            src2_q    <= 4'd0;
            sinal_q   <= 1'b0;
            imm_q     <= 6'd0;
            addr_q    <= 4'd0;
            cnt_q     <= 4'd0;
            v1_q      <= 16'h0000;
            v2_q      <= 16'h0000;
            disp_q    <= 16'h0000;
            regdisp_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            enviar_q  <= enviar;
            opcode_q  <= opcode_d;
            dest_q    <= dest_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            sinal_q   <= sinal_d;
            imm_q     <= imm_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            disp_q    <= disp_d;
            regdisp_q <= regdisp_d;
        end
    end

    assign bus.ramEndereco     = addr_d;
    assign bus.ramEscrever     = we;
    assign bus.ramDadoEscrever = wdata;
    assign bus.opcodeULA       = opcode_q;
    assign bus.sinalImmULA     = sinal_q;
    assign bus.ImmULA          = imm_q;
    assign bus.v1ULA           = v1_q;
    assign bus.v2ULA           = v2_q;
    assign valorDisplay        = disp_q;
    assign regDisplay          = regdisp_q;
    assign ocupado             = (state_q != OCIOSO);
    assign pronto              = (state_q == FIM);

endmodule

// File: tb/tb_module_controle.sv
// Bench for module_controle: RAM and ALU models on the slave bus, write scoreboard,
// directed LOAD/ADD/SUBI/CLEAR/DISPLAY/reset/held-button scenarios.
module tb_module_controle;

    logic        clk;
    logic        reset;
    logic        enviar;
    logic [17:0] instrucao;
    logic [15:0] valorDisplay;
    logic [3:0]  regDisplay;
    logic        ocupado;
    logic        pronto;

    module_controle_if bus ();

    module_controle dut (
        .clk          (clk),
        .reset        (reset),
        .enviar       (enviar),
        .instrucao    (instrucao),
        .bus          (bus),
        .valorDisplay (valorDisplay),
        .regDisplay   (regDisplay),
        .ocupado      (ocupado),
        .pronto       (pronto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_cnt = 0;
    int pronto_cnt = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;
    wr_t sb[$];

    // NOTE: the RAM model has no reset; its contents persist across the bench's reset pulses like real RAM.
    logic [15:0] mem [16];
    logic        pre_we;
    logic [3:0]  pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.ramDadoLido <= mem[bus.ramEndereco];
        if (bus.ramEscrever)
            mem[bus.ramEndereco] <= bus.ramDadoEscrever;
        else if (pre_we)
            mem[pre_addr] <= pre_data;
    end

    function automatic logic [15:0] alu_model(input logic [2:0] op, input logic s, input logic [5:0] imm,
                                              input logic [15:0] a, input logic [15:0] b);
        logic [15:0] i16;
        i16 = s ? (16'h0000 - {10'd0, imm}) : {10'd0, imm};
        case (op)
            3'b000:  return i16;
            3'b001:  return a + b;
            3'b010:  return a + i16;
            3'b011:  return a - b;
            3'b100:  return a - i16;
            3'b101:  return a * i16;
            default: return 16'h0000;
        endcase
    endfunction

    assign bus.valorGuardarULA = alu_model(bus.opcodeULA, bus.sinalImmULA, bus.ImmULA, bus.v1ULA, bus.v2ULA);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer: every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (pronto) pronto_cnt <= pronto_cnt + 1;
        if (bus.ramEscrever === 1'b1) begin
            wr_cnt <= wr_cnt + 1;
            if (sb.size() == 0) begin
                check("unexpected_write", {28'd0, bus.ramEndereco}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", {28'd0, bus.ramEndereco}, {28'd0, e.addr});
                check("wr_data", {16'd0, bus.ramDadoEscrever}, {16'd0, e.data});
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    // Fresh 0->1 edge; returns the c0 cycle number and leaves time in c1.
    task automatic issue(input logic [17:0] ins, output int c0);
        enviar = 1'b0;
        tick();
        instrucao = ins;
        enviar    = 1'b1;
        c0        = cyc;
        tick();
    endtask

    int c0;
    int w0;
    int p0;

    initial begin
        reset = 1'b1; enviar = 1'b0; instrucao = 18'd0;
        pre_we = 1'b0; pre_addr = 4'd0; pre_data = 16'h0000;
        tick(); tick();
        check("rst_ocupado", {31'd0, ocupado}, 32'd0);
        check("rst_pronto", {31'd0, pronto}, 32'd0);
        check("rst_we", {31'd0, bus.ramEscrever}, 32'd0);
        check("rst_addr", {28'd0, bus.ramEndereco}, 32'd0);
        check("rst_v1", {16'd0, bus.v1ULA}, 32'd0);
        check("rst_disp", {16'd0, valorDisplay}, 32'd0);
        reset = 1'b0;
        tick();

        // LOAD dest=1 Imm=+5
        issue({3'b000, 4'd1, 4'd0, 1'b0, 6'd5}, c0);
        sb.push_back('{4'd1, 16'd5, c0 + 2});
        check("load_c1_ocupado", {31'd0, ocupado}, 32'd1);
        check("load_c1_imm", {26'd0, bus.ImmULA}, 32'd5);
        check("load_c1_pronto", {31'd0, pronto}, 32'd0);
        tick();
        check("load_c2_we", {31'd0, bus.ramEscrever}, 32'd1);
        check("load_c2_addr", {28'd0, bus.ramEndereco}, 32'd1);
        tick();
        check("load_c3_pronto", {31'd0, pronto}, 32'd1);
        check("load_c3_ocupado", {31'd0, ocupado}, 32'd1);
        tick();
        check("load_c4_ocupado", {31'd0, ocupado}, 32'd0);
        check("load_mem1", {16'd0, mem[1]}, 32'd5);

        // ADD dest=4 src1=2 src2=3
        preload(4'd2, 16'd7);
        preload(4'd3, 16'd9);
        issue({3'b001, 4'd4, 4'd2, 4'd3, 3'd0}, c0);
        sb.push_back('{4'd4, 16'd16, c0 + 4});
        check("add_c1_addr", {28'd0, bus.ramEndereco}, 32'd2);
        tick();
        check("add_c2_addr", {28'd0, bus.ramEndereco}, 32'd3);
        tick();
        check("add_c3_v1", {16'd0, bus.v1ULA}, 32'd7);
        check("add_c3_pronto", {31'd0, pronto}, 32'd0);
        tick();
        check("add_c4_v2", {16'd0, bus.v2ULA}, 32'd9);
        check("add_c4_data", {16'd0, bus.ramDadoEscrever}, 32'd16);
        tick();
        check("add_c5_pronto", {31'd0, pronto}, 32'd1);
        tick();
        check("add_mem4", {16'd0, mem[4]}, 32'd16);

        // SUBI with dest aliasing src1: r3 = r3 - 4
        issue({3'b100, 4'd3, 4'd3, 1'b0, 6'd4}, c0);
        sb.push_back('{4'd3, 16'd5, c0 + 4});
        repeat (5) tick();
        check("subi_v1", {16'd0, bus.v1ULA}, 32'd9);
        check("subi_v2_zero", {16'd0, bus.v2ULA}, 32'd0);
        check("subi_mem3", {16'd0, mem[3]}, 32'd5);

        // CLEAR full sweep
        for (int i = 0; i < 16; i++) preload(i[3:0], 16'hFFFF);
        w0 = wr_cnt;
        issue({3'b110, 15'd0}, c0);
        for (int i = 0; i < 16; i++) sb.push_back('{i[3:0], 16'h0000, c0 + 1 + i});
        for (int k = 1; k <= 16; k++) begin
            check("clr_we", {31'd0, bus.ramEscrever}, 32'd1);
            check("clr_addr", {28'd0, bus.ramEndereco}, k - 1);
            check("clr_pronto_early", {31'd0, pronto}, 32'd0);
            tick();
        end
        check("clr_c17_pronto", {31'd0, pronto}, 32'd1);
        tick();
        check("clr_ocupado_end", {31'd0, ocupado}, 32'd0);
        check("clr_write_count", wr_cnt - w0, 32'd16);
        check("clr_mem0", {16'd0, mem[0]}, 32'd0);
        check("clr_mem15", {16'd0, mem[15]}, 32'd0);

        // DISPLAY dest=6
        preload(4'd6, 16'h00AB);
        w0 = wr_cnt;
        issue({3'b111, 4'd6, 11'd0}, c0);
        check("disp_c1_addr", {28'd0, bus.ramEndereco}, 32'd6);
        tick();
        check("disp_c2_old", {16'd0, valorDisplay}, 32'd0);
        tick();
        check("disp_c3_val", {16'd0, valorDisplay}, 32'h00AB);
        check("disp_c3_reg", {28'd0, regDisplay}, 32'd6);
        check("disp_c3_pronto", {31'd0, pronto}, 32'd1);
        tick();
        check("disp_no_write", wr_cnt - w0, 32'd0);

        // Reset in c8 of a CLEAR
        for (int i = 0; i < 16; i++) preload(i[3:0], 16'hFFFF);
        p0 = pronto_cnt;
        issue({3'b110, 15'd0}, c0);
        for (int i = 0; i < 7; i++) sb.push_back('{i[3:0], 16'h0000, c0 + 1 + i});
        repeat (7) tick();
        reset = 1'b1;
        tick();
        check("mid_ocupado", {31'd0, ocupado}, 32'd0);
        check("mid_pronto", {31'd0, pronto}, 32'd0);
        check("mid_we", {31'd0, bus.ramEscrever}, 32'd0);
        check("mid_addr", {28'd0, bus.ramEndereco}, 32'd0);
        check("mid_wdata", {16'd0, bus.ramDadoEscrever}, 32'd0);
        check("mid_opcode", {29'd0, bus.opcodeULA}, 32'd0);
        check("mid_imm", {25'd0, bus.sinalImmULA, bus.ImmULA}, 32'd0);
        check("mid_v1v2", {bus.v1ULA, bus.v2ULA}, 32'd0);
        check("mid_disp", {12'd0, regDisplay, valorDisplay}, 32'd0);
        reset = 1'b0;
        repeat (20) tick();
        check("mid_no_pronto", pronto_cnt - p0, 32'd0);
        check("mid_idle", {31'd0, ocupado}, 32'd0);
        for (int i = 0; i < 7; i++) check("mid_mem_cleared", {16'd0, mem[i]}, 32'd0);
        for (int i = 7; i < 16; i++) check("mid_mem_kept", {16'd0, mem[i]}, 32'hFFFF);

        // Button held through reset release, then one press, then a press while busy
        reset  = 1'b1;
        enviar = 1'b1;
        instrucao = {3'b000, 4'd9, 4'd0, 1'b1, 6'd3};
        tick(); tick();
        reset = 1'b0;
        repeat (3) begin
            tick();
            check("held_no_start", {31'd0, ocupado}, 32'd0);
        end
        p0 = pronto_cnt;
        enviar = 1'b0;
        tick();
        enviar = 1'b1;
        c0 = cyc;
        tick();
        sb.push_back('{4'd9, 16'hFFFD, c0 + 2});
        check("held_c1_ocupado", {31'd0, ocupado}, 32'd1);
        enviar = 1'b0;
        tick();
        enviar = 1'b1;
        tick();
        check("held_c3_pronto", {31'd0, pronto}, 32'd1);
        repeat (4) begin
            tick();
            check("held_busy_press_ignored", {31'd0, ocupado}, 32'd0);
        end
        check("held_one_instr", pronto_cnt - p0, 32'd1);
        check("held_mem9", {16'd0, mem[9]}, 32'hFFFD);

        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
